// File: rtl/game_round_ctrl.sv
// Purpose : round sequencer for the 4x4 whack-a-target game (spawn, hit/timeout, boom, gap, score keeping).
// Latency : every output is registered; a decision taken at an edge is visible right after that edge.
// Backpres: none; hit_valid is a one-cycle strobe, finish_boom is sampled every cycle while animating.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset, overrides every other input
//   start        level, starts a new game from IDLE or DONE
//   hit_valid    one-cycle strobe, player pressed hit_pos = {row[1:0], col[1:0]}
//   finish_boom  display controller reports the explosion animation is complete
//   disp_en, disp_pos, disp_color, show_boom   to the point-matrix display controller
//   score, miss_cnt, round_cnt, game_over      game status
module game_round_ctrl #(
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter int         GAP_CYC     = 250_000,
  parameter int         ROUNDS      = 10,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit_valid,
  input  logic [3:0] hit_pos,
  input  logic       finish_boom,
  output logic       disp_en,
  output logic [3:0] disp_pos,
  output logic [1:0] disp_color,
  output logic       show_boom,
  output logic [6:0] score,
  output logic [6:0] miss_cnt,
  output logic [6:0] round_cnt,
  output logic       game_over
);

  // One shared down-counter serves both the target timeout and the inter-round gap.
  localparam int TMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYC - 1);
  localparam logic [6:0]    ROUNDS_L = 7'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_WAIT,
    S_BOOM,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    lfsr;
  logic          lfsr_fb;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    pos_nxt;
  logic [1:0]    color_nxt;
  logic [6:0]    score_nxt, miss_nxt, round_nxt;
  logic [6:0]    round_inc;
  logic [1:0]    miss_inc;
  logic [7:0]    miss_sum;
  logic          hit_ok;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pos_nxt   = disp_pos;
    color_nxt = disp_color;
    score_nxt = score;
    miss_nxt  = miss_cnt;
    round_nxt = round_cnt;
    round_inc = round_cnt + 7'd1;
    miss_inc  = 2'd0;
    miss_sum  = 8'd0;
    hit_ok    = hit_valid && (hit_pos == disp_pos);

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          score_nxt = 7'd0;
          miss_nxt  = 7'd0;
          round_nxt = 7'd0;
          state_nxt = S_SPAWN;
        end
      end

      S_SPAWN: begin
        // Never light the same cell twice in a row within a game.
        if ((round_cnt != 7'd0) && (lfsr[3:0] == disp_pos)) begin
          pos_nxt = lfsr[3:0] + 4'd1;
        end else begin
          pos_nxt = lfsr[3:0];
        end
        // Colour 00 means "off" on the display, so remap it.
        color_nxt = (lfsr[5:4] == 2'b00) ? 2'b01 : lfsr[5:4];
        timer_nxt = TO_LOAD;
        state_nxt = S_WAIT;
      end

      S_WAIT: begin
        timer_nxt = timer - TW'(1);
        if (hit_ok) begin
          // A correct hit beats a simultaneous timeout.
          score_nxt = (score < ROUNDS_L) ? score + 7'd1 : score;
          state_nxt = S_BOOM;
        end else begin
          if (hit_valid) begin
            miss_inc = miss_inc + 2'd1;
          end
          if (timer == '0) begin
            miss_inc  = miss_inc + 2'd1;
            timer_nxt = GAP_LOAD;
            state_nxt = S_GAP;
          end
        end
      end

      S_BOOM: begin
        if (finish_boom) begin
          timer_nxt = GAP_LOAD;
          state_nxt = S_GAP;
        end
      end

      S_GAP: begin
        if (timer == '0) begin
          round_nxt = round_inc;
          state_nxt = (round_inc == ROUNDS_L) ? S_DONE : S_SPAWN;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    if (miss_inc != 2'd0) begin
      miss_sum = {1'b0, miss_cnt} + {6'd0, miss_inc};
      miss_nxt = (miss_sum > 8'd127) ? 7'd127 : miss_sum[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lfsr       <= LFSR_SEED;
      timer      <= '0;
      disp_en    <= 1'b0;
      disp_pos   <= 4'd0;
      disp_color <= 2'd0;
      show_boom  <= 1'b0;
      score      <= 7'd0;
      miss_cnt   <= 7'd0;
      round_cnt  <= 7'd0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      lfsr       <= {lfsr[6:0], lfsr_fb};
      timer      <= timer_nxt;
      disp_pos   <= pos_nxt;
      disp_color <= color_nxt;
      score      <= score_nxt;
      miss_cnt   <= miss_nxt;
      round_cnt  <= round_nxt;
      // Status outputs are decoded from the next state so they track the state register exactly.
      disp_en    <= (state_nxt == S_WAIT) || (state_nxt == S_BOOM);
      show_boom  <= (state_nxt == S_BOOM);
      game_over  <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
module tb_game_round_ctrl;

  localparam int         T_TO   = 20;
  localparam int         T_GAP  = 4;
  localparam int         T_RNDS = 3;
  localparam logic [7:0] SEED   = 8'hA5;

  localparam int P_IDLE  = 0;
  localparam int P_SPAWN = 1;
  localparam int P_WAIT  = 2;
  localparam int P_BOOM  = 3;
  localparam int P_GAP   = 4;
  localparam int P_DONE  = 5;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       hit_valid;
  logic [3:0] hit_pos;
  logic       finish_boom;
  logic       disp_en;
  logic [3:0] disp_pos;
  logic [1:0] disp_color;
  logic       show_boom;
  logic [6:0] score;
  logic [6:0] miss_cnt;
  logic [6:0] round_cnt;
  logic       game_over;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  // Reference model state (game-level view).
  int         m_ph;
  int         m_left;
  logic [7:0] m_lf;
  int         m_pos, m_col, m_score, m_miss, m_rnd;

  game_round_ctrl #(
    .TIMEOUT_CYC(T_TO),
    .GAP_CYC    (T_GAP),
    .ROUNDS     (T_RNDS),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .hit_valid  (hit_valid),
    .hit_pos    (hit_pos),
    .finish_boom(finish_boom),
    .disp_en    (disp_en),
    .disp_pos   (disp_pos),
    .disp_color (disp_color),
    .show_boom  (show_boom),
    .score      (score),
    .miss_cnt   (miss_cnt),
    .round_cnt  (round_cnt),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic fb;
    fb = ^(v & 8'hB8);
    return {v[6:0], fb};
  endfunction

  function automatic int sat127(input int v);
    return (v > 127) ? 127 : v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_ne(input string nm, input logic [31:0] act, input logic [31:0] bad);
    n_cmp++;
    if (act === bad || $isunknown(act)) begin
      n_bad++;
      $display("FAIL %s: got %0h, must differ from %0h (t=%0t)", nm, act, bad, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // kind 0: target lit without animation; kind 1: game over.
  task automatic wait_dut(input int kind, input string nm);
    int n;
    n = 0;
    while (n < 200 && !((kind == 0) ? (disp_en === 1'b1 && show_boom === 1'b0)
                                    : (game_over === 1'b1))) begin
      tick();
      n++;
    end
    check(nm, (n < 200), 1);
  endtask

  // Model: advances one clock per posedge from the rules of the game.
  task automatic model_step;
    int p;
    if (!rst_n) begin
      m_ph = P_IDLE; m_left = 0; m_lf = SEED;
      m_pos = 0; m_col = 0; m_score = 0; m_miss = 0; m_rnd = 0;
    end else begin
      case (m_ph)
        P_IDLE, P_DONE: begin
          if (start) begin
            m_score = 0; m_miss = 0; m_rnd = 0;
            m_ph = P_SPAWN;
          end
        end
        P_SPAWN: begin
          p = int'(m_lf) % 16;
          if (m_rnd > 0 && p == m_pos) p = (p + 1) % 16;
          m_pos = p;
          m_col = (int'(m_lf) / 16) % 4;
          if (m_col == 0) m_col = 1;
          m_left = T_TO;
          m_ph = P_WAIT;
        end
        P_WAIT: begin
          if (hit_valid && int'(hit_pos) == m_pos) begin
            m_score = m_score + 1;
            m_ph = P_BOOM;
          end else begin
            if (hit_valid) m_miss = sat127(m_miss + 1);
            m_left = m_left - 1;
            if (m_left == 0) begin
              m_miss = sat127(m_miss + 1);
              m_left = T_GAP;
              m_ph = P_GAP;
            end
          end
        end
        P_BOOM: begin
          if (finish_boom) begin
            m_left = T_GAP;
            m_ph = P_GAP;
          end
        end
        P_GAP: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_rnd = m_rnd + 1;
            m_ph = (m_rnd == T_RNDS) ? P_DONE : P_SPAWN;
          end
        end
        default: m_ph = P_IDLE;
      endcase
      m_lf = lfsr_step(m_lf);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("m_disp_en",    disp_en,    (m_ph == P_WAIT || m_ph == P_BOOM));
        check("m_show_boom",  show_boom,  (m_ph == P_BOOM));
        check("m_game_over",  game_over,  (m_ph == P_DONE));
        check("m_disp_pos",   disp_pos,   m_pos);
        check("m_disp_color", disp_color, m_col);
        check("m_score",      score,      m_score);
        check("m_miss_cnt",   miss_cnt,   m_miss);
        check("m_round_cnt",  round_cnt,  m_rnd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] p_first;

    rst_n = 1'b0; start = 1'b0; hit_valid = 1'b0; hit_pos = 4'd0; finish_boom = 1'b0;
    repeat (5) tick();
    chk_on = 1;
    check("rst_en",    disp_en,    0);
    check("rst_boom",  show_boom,  0);
    check("rst_pos",   disp_pos,   0);
    check("rst_color", disp_color, 0);
    check("rst_score", score,      0);
    check("rst_miss",  miss_cnt,   0);
    check("rst_round", round_cnt,  0);
    check("rst_over",  game_over,  0);

    // Idle with start low: nothing lights up.
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_en", disp_en, 0);
    end

    // Round 1: correct hit on the 5th lit cycle, animation for 3 cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_dut(0, "wait_r1");
    p_first = 4'(m_pos);
    repeat (4) tick();
    hit_valid = 1'b1; hit_pos = 4'(m_pos);
    tick();
    hit_valid = 1'b0;
    check("hit_score", score,     1);
    check("hit_boom",  show_boom, 1);
    check("hit_pos",   disp_pos,  p_first);
    repeat (2) tick();
    finish_boom = 1'b1;
    tick();
    finish_boom = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("gap_boom", show_boom, 0);
      check("gap_en",   disp_en,   0);
      tick();
    end
    check("r1_round", round_cnt, 1);
    tick();
    check_ne("r2_newpos", disp_pos,   p_first);
    check_ne("r2_color",  disp_color, 0);

    // Round 2: one wrong press, then let it time out.
    hit_valid = 1'b1; hit_pos = 4'(m_pos) ^ 4'h1;
    tick();
    hit_valid = 1'b0;
    check("wrong_miss", miss_cnt, 1);
    repeat (18) tick();
    check("to_pre_miss", miss_cnt, 1);
    check("to_pre_en",   disp_en,  1);
    tick();
    check("to_miss", miss_cnt,  2);
    check("to_boom", show_boom, 0);
    check("to_en",   disp_en,   0);

    // Round 3: correct hit on the last lit cycle.
    wait_dut(0, "wait_r3");
    check("r3_round", round_cnt, 2);
    repeat (19) tick();
    hit_valid = 1'b1; hit_pos = 4'(m_pos);
    tick();
    hit_valid = 1'b0;
    check("sim_score", score,     2);
    check("sim_miss",  miss_cnt,  2);
    check("sim_boom",  show_boom, 1);
    finish_boom = 1'b1;
    tick();
    finish_boom = 1'b0;

    // Game over and hold.
    wait_dut(1, "wait_done");
    check("done_round", round_cnt, 3);
    check("done_score", score,     2);
    repeat (10) tick();
    check("hold_over",  game_over, 1);
    check("hold_round", round_cnt, 3);
    check("hold_score", score,     2);
    check("hold_miss",  miss_cnt,  2);
    check("hold_en",    disp_en,   0);

    // Restart clears everything.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_over",  game_over, 0);
    check("rs_score", score,     0);
    check("rs_miss",  miss_cnt,  0);
    check("rs_round", round_cnt, 0);
    check("rs_en",    disp_en,   0);

    // Reset in the middle of an animation.
    wait_dut(0, "wait_rs");
    hit_valid = 1'b1; hit_pos = 4'(m_pos);
    tick();
    hit_valid = 1'b0;
    check("rb_boom",  show_boom, 1);
    tick();
    rst_n = 1'b0;
    tick();
    check("rb_boom0", show_boom, 0);
    check("rb_en0",   disp_en,   0);
    check("rb_score", score,     0);
    check("rb_over",  game_over, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("rb_idle_en", disp_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round sequencer for the 4x4 whack-a-target game; drives the game point-matrix display controller (pos, color, en, showBoom) and consumes its finishBoom.
- Each round spawns a target at a pseudo-random cell, waits for a player hit or a timeout, then plays the explosion animation (hit) or skips it (miss).
- Keeps score, miss count and round count, and flags game over after ROUNDS rounds.

Parameters:
- TIMEOUT_CYC, 1_000_000, clk cycles a target stays lit before counting as a miss (1 s at 1 MHz).
- GAP_CYC, 250_000, blank cycles between rounds.
- ROUNDS, 10, rounds per game; legal range 1..127.
- LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  level; sampled in IDLE/DONE, starts a new game.
- hit_valid  in  1  one-cycle strobe, player pressed a cell.
- hit_pos  in  4  pressed cell, {row[1:0], col[1:0]}.
- finish_boom  in  1  from display controller, animation complete.
- disp_en  out  1  to display en.
- disp_pos  out  4  to display pos.
- disp_color  out  2  to display color, never 2'b00 while disp_en=1.
- show_boom  out  1  to display showBoom.
- score  out  7  hits this game.
- miss_cnt  out  7  timeouts plus wrong-cell presses this game.
- round_cnt  out  7  completed rounds.
- game_over  out  1  high in DONE.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all outputs 0; LFSR=LFSR_SEED; timer=0. Reset wins over every other input, including mid-round and mid-animation.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts every cycle when not in reset, independent of state.
  - Held in reset only.
- IDLE: disp_en=0, show_boom=0. If start=1, clear score, miss_cnt, round_cnt; next state SPAWN.
- SPAWN (exactly 1 cycle):
  - disp_pos <= lfsr[3:0]. If that equals the previous round's disp_pos (round_cnt>0), use lfsr[3:0]+1 mod 16 instead.
  - disp_color <= lfsr[5:4]; if that is 2'b00, use 2'b01.
  - timer <= TIMEOUT_CYC-1.
  - Next state WAIT_HIT.
- WAIT_HIT:
  - disp_en=1. timer decrements each cycle.
  - hit_valid and hit_pos==disp_pos: score+1, then BOOM.
  - hit_valid and hit_pos!=disp_pos: miss_cnt+1; stay in WAIT_HIT, timer keeps running.
  - timer==0 with no correct hit: miss_cnt+1, then GAP.
  - Correct hit in the same cycle as timer==0: hit wins; score+1 only, no miss.
- BOOM:
  - show_boom=1, disp_en=1; disp_pos and disp_color held.
  - On finish_boom=1: next state GAP. show_boom drops on that transition edge, so the display resets its animation.
- GAP:
  - disp_en=0, show_boom=0. timer loaded with GAP_CYC-1 on entry, counts to 0.
  - At 0: round_cnt+1. If the new round_cnt==ROUNDS go to DONE, else SPAWN.
- DONE:
  - game_over=1, disp_en=0; score, miss_cnt, round_cnt held.
  - start=1: clear counters and game_over; next state SPAWN.
- Output register rules:
  - All outputs are registered; a state change is visible one cycle after the deciding edge.
  - disp_pos and disp_color change only in SPAWN.
- Counters:
  - score and round_cnt never exceed ROUNDS.
  - miss_cnt saturates at 127.
- hit_valid is ignored outside WAIT_HIT (no miss counted). start is ignored outside IDLE/DONE.

Test Plan:
- Bench parameters for all cases: TIMEOUT_CYC=20, GAP_CYC=4, ROUNDS=3.
- Reset/idle: hold rst_n=0 5 cycles, release with start=0 -> all outputs 0, stays IDLE, disp_en=0 for 50 cycles.
- Hit path:
  - start, read disp_pos=P; pulse hit_valid with hit_pos=P on the 5th WAIT_HIT cycle -> score=1, show_boom=1 next cycle.
  - Hold finish_boom=1 after 3 cycles -> show_boom=0, disp_en=0 for 4 cycles, round_cnt=1, new disp_pos!=P, disp_color!=0.
- Timeout and wrong cell:
  - hit_valid with hit_pos=P^4'h1 once, then no input -> miss_cnt=1 immediately; after 20 WAIT_HIT cycles miss_cnt=2, no show_boom, GAP entered.
- Simultaneous: correct hit on the cycle timer==0 -> score+1, miss_cnt unchanged, BOOM entered.
- Game over and restart:
  - Complete 3 rounds -> game_over=1, round_cnt=3, counters held with start=0.
  - Assert start -> counters 0, game_over=0, SPAWN next.
- Reset mid-BOOM: drop rst_n while show_boom=1 -> next edge show_boom=0, disp_en=0, score=0, state IDLE.
